// File: rtl/uart_tx_port_bridge_if.sv
// Port-level bundle between a core output/input register pair and the UART bridge.
// The master is the core side; the slave is the bridge.
interface uart_tx_port_bridge_if;
  logic [31:0] txCommand;
  logic [31:0] txStatus;
  logic        txSerial;

  modport master (output txCommand, input txStatus, input txSerial);
  modport slave  (input txCommand, output txStatus, output txSerial);
endinterface

// File: rtl/uart_tx_port_bridge.sv
// 8N1 UART transmitter driven by a toggle handshake over plain level ports.
// A request is pending whenever the command toggle differs from the ack toggle.
module uart_tx_port_bridge #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                  clock,
  input  logic                  reset,
  uart_tx_port_bridge_if.slave  bus
);

  generate
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : gBadClksPerBit
      $error("uart_tx_port_bridge: CLKS_PER_BIT must be within 2..65535");
    end
  endgenerate

  localparam int              BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_e;

  txState_e          stateReg,    stateNext;
  logic [BAUD_W-1:0] baudReg,     baudNext;
  logic [2:0]        bitIndexReg, bitIndexNext;
  logic [7:0]        shiftReg,    shiftNext;
  logic [7:0]        lastByteReg, lastByteNext;
  logic [7:0]        countReg,    countNext;
  logic              ackReg,      ackNext;
  logic              busyReg,     busyNext;
  logic              serialReg,   serialNext;

  logic       requestPending;
  logic       baudDone;
  logic [2:0] bitIndexInc;
  logic       unusedCmdBits;

  assign requestPending = (bus.txCommand[31] != ackReg);
  assign baudDone       = (baudReg == BAUD_LAST);
  assign bitIndexInc    = bitIndexReg + 3'd1;
  // Command bits 30:8 are reserved on the core port and deliberately ignored.
  assign unusedCmdBits  = ^bus.txCommand[30:8];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateReg    <= IDLE;
      baudReg     <= '0;
      bitIndexReg <= 3'd0;
      shiftReg    <= 8'd0;
      lastByteReg <= 8'd0;
      countReg    <= 8'd0;
      ackReg      <= 1'b0;
      busyReg     <= 1'b0;
      serialReg   <= 1'b1;
    end else begin
      stateReg    <= stateNext;
      baudReg     <= baudNext;
      bitIndexReg <= bitIndexNext;
      shiftReg    <= shiftNext;
      lastByteReg <= lastByteNext;
      countReg    <= countNext;
      ackReg      <= ackNext;
      busyReg     <= busyNext;
      serialReg   <= serialNext;
    end
  end

  // Line level is registered alongside the state so every bit, including the
  // start bit, lasts exactly CLKS_PER_BIT cycles from the edge that enters it.
  always_comb begin
    stateNext    = stateReg;
    baudNext     = baudReg;
    bitIndexNext = bitIndexReg;
    shiftNext    = shiftReg;
    lastByteNext = lastByteReg;
    countNext    = countReg;
    ackNext      = ackReg;
    busyNext     = busyReg;
    serialNext   = serialReg;

    unique case (stateReg)
      IDLE: begin
        serialNext = 1'b1;
        busyNext   = 1'b0;
        if (requestPending) begin
          stateNext    = START;
          ackNext      = ~ackReg;
          shiftNext    = bus.txCommand[7:0];
          lastByteNext = bus.txCommand[7:0];
          serialNext   = 1'b0;
          baudNext     = '0;
          busyNext     = 1'b1;
        end
      end

      START: begin
        if (baudDone) begin
          stateNext    = DATA;
          baudNext     = '0;
          bitIndexNext = 3'd0;
          serialNext   = shiftReg[0];
        end else begin
          baudNext = baudReg + BAUD_W'(1);
        end
      end

      DATA: begin
        if (baudDone) begin
          baudNext = '0;
          if (bitIndexReg == 3'd7) begin
            stateNext  = STOP;
            serialNext = 1'b1;
          end else begin
            bitIndexNext = bitIndexInc;
            serialNext   = shiftReg[bitIndexInc];
          end
        end else begin
          baudNext = baudReg + BAUD_W'(1);
        end
      end

      STOP: begin
        if (baudDone) begin
          stateNext  = IDLE;
          baudNext   = '0;
          countNext  = countReg + 8'd1;
          busyNext   = 1'b0;
          serialNext = 1'b1;
        end else begin
          baudNext = baudReg + BAUD_W'(1);
        end
      end

      default: begin
        stateNext  = IDLE;
        busyNext   = 1'b0;
        serialNext = 1'b1;
      end
    endcase
  end

  assign bus.txSerial = serialReg;
  assign bus.txStatus = {ackReg, busyReg, 6'd0, countReg, 8'd0, lastByteReg};

endmodule

// File: tb/tb_uart_tx_port_bridge.sv
// Directed bench for uart_tx_port_bridge: one instance at 4 clocks/bit, one at 2.
// Outputs are sampled on the falling edge; inputs are driven there too.
module tb_uart_tx_port_bridge;

  logic clock = 1'b0;
  logic reset;
  int   assertCount = 0;
  int   failCount   = 0;

  always #5 clock = ~clock;

  uart_tx_port_bridge_if ifc4 ();
  uart_tx_port_bridge_if ifc2 ();

  uart_tx_port_bridge #(.CLKS_PER_BIT(4)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (ifc4)
  );

  uart_tx_port_bridge #(.CLKS_PER_BIT(2)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (ifc2)
  );

  // Line level of 8N1 frame slot idx: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic frameBit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return d[idx-1];
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    ifc4.txCommand = 32'h0;
    ifc2.txCommand = 32'h0;
    repeat (2) @(negedge clock);
    assertCount++;
    if (ifc4.txSerial !== 1'b1 || ifc2.txSerial !== 1'b1) begin
      failCount++;
      $display("FAIL reset_serial: got %b/%b, expected 1/1", ifc4.txSerial, ifc2.txSerial);
    end
    assertCount++;
    if (ifc4.txStatus !== 32'h0 || ifc2.txStatus !== 32'h0) begin
      failCount++;
      $display("FAIL reset_status: got %h/%h, expected 00000000", ifc4.txStatus, ifc2.txStatus);
    end
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      assertCount++;
      if (ifc4.txSerial !== 1'b1 || ifc4.txStatus !== 32'h0 ||
          ifc2.txSerial !== 1'b1 || ifc2.txStatus !== 32'h0) begin
        failCount++;
        $display("FAIL idle_cycle %0d: serial %b/%b status %h/%h, expected 1/1 00000000",
                 i, ifc4.txSerial, ifc2.txSerial, ifc4.txStatus, ifc2.txStatus);
      end
    end
    $display("test_reset: 50 idle cycles after reset checked");
  endtask

  task automatic test_single_frame();
    ifc4.txCommand = 32'h80000055;
    @(negedge clock);
    assertCount++;
    if (ifc4.txStatus !== 32'hC0000055 || ifc4.txSerial !== 1'b0) begin
      failCount++;
      $display("FAIL accept_55: status %h serial %b, expected C0000055 0", ifc4.txStatus, ifc4.txSerial);
    end
    for (int i = 1; i < 40; i++) begin
      @(negedge clock);
      assertCount++;
      if (ifc4.txSerial !== frameBit(8'h55, i / 4) || ifc4.txStatus[30] !== 1'b1) begin
        failCount++;
        $display("FAIL frame_55 cycle %0d: serial %b busy %b, expected %b 1",
                 i, ifc4.txSerial, ifc4.txStatus[30], frameBit(8'h55, i / 4));
      end
    end
    @(negedge clock);
    assertCount++;
    if (ifc4.txStatus !== 32'h80010055 || ifc4.txSerial !== 1'b1) begin
      failCount++;
      $display("FAIL end_55: status %h serial %b, expected 80010055 1", ifc4.txStatus, ifc4.txSerial);
    end
    $display("test_single_frame: byte 0x55 sent, status %h", ifc4.txStatus);
  endtask

  task automatic test_back_to_back();
    logic expSerial;
    logic expBusy;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    ifc4.txCommand = 32'h80000055;
    for (int i = 0; i <= 81; i++) begin
      @(negedge clock);
      if (i == 0) begin
        assertCount++;
        if (ifc4.txStatus !== 32'hC0000055) begin
          failCount++;
          $display("FAIL b2b_ack1: status %h, expected C0000055", ifc4.txStatus);
        end
        ifc4.txCommand = 32'h000000A3;
      end
      if (i < 40)      begin expSerial = frameBit(8'h55, i / 4);        expBusy = 1'b1; end
      else if (i == 40) begin expSerial = 1'b1;                         expBusy = 1'b0; end
      else if (i < 81) begin expSerial = frameBit(8'hA3, (i - 41) / 4); expBusy = 1'b1; end
      else             begin expSerial = 1'b1;                          expBusy = 1'b0; end
      assertCount++;
      if (ifc4.txSerial !== expSerial || ifc4.txStatus[30] !== expBusy) begin
        failCount++;
        $display("FAIL b2b_line cycle %0d: serial %b busy %b, expected %b %b",
                 i, ifc4.txSerial, ifc4.txStatus[30], expSerial, expBusy);
      end
      if (i == 41) begin
        assertCount++;
        if (ifc4.txStatus !== 32'h400100A3) begin
          failCount++;
          $display("FAIL b2b_second_start: status %h, expected 400100A3", ifc4.txStatus);
        end
      end
      if (i == 81) begin
        assertCount++;
        if (ifc4.txStatus !== 32'h000200A3) begin
          failCount++;
          $display("FAIL b2b_end: status %h, expected 000200A3", ifc4.txStatus);
        end
      end
    end
    $display("test_back_to_back: 0x55 then 0xA3, status %h", ifc4.txStatus);
  endtask

  task automatic test_data_stability();
    ifc4.txCommand = 32'h80000096;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (i == 0) begin
        assertCount++;
        if (ifc4.txStatus !== 32'hC0020096) begin
          failCount++;
          $display("FAIL stab_accept: status %h, expected C0020096", ifc4.txStatus);
        end
      end
      // Data changes, then a double toggle that must cancel itself.
      if (i == 6)  ifc4.txCommand = 32'h800000FF;
      if (i == 10) ifc4.txCommand = 32'h000000FF;
      if (i == 14) ifc4.txCommand = 32'h800000FF;
      assertCount++;
      if (ifc4.txSerial !== ((i < 40) ? frameBit(8'h96, i / 4) : 1'b1) ||
          ifc4.txStatus[30] !== (i < 40)) begin
        failCount++;
        $display("FAIL stab_line cycle %0d: serial %b busy %b, expected %b %b", i,
                 ifc4.txSerial, ifc4.txStatus[30],
                 ((i < 40) ? frameBit(8'h96, i / 4) : 1'b1), (i < 40));
      end
    end
    assertCount++;
    if (ifc4.txStatus !== 32'h80030096) begin
      failCount++;
      $display("FAIL stab_end: status %h, expected 80030096", ifc4.txStatus);
    end
    $display("test_data_stability: byte 0x96 unaffected, status %h", ifc4.txStatus);
  endtask

  task automatic test_reset_mid_frame();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    ifc4.txCommand = 32'h800000C3;
    for (int i = 0; i <= 17; i++) begin
      @(negedge clock);
      assertCount++;
      if (ifc4.txSerial !== frameBit(8'hC3, i / 4)) begin
        failCount++;
        $display("FAIL pre_reset cycle %0d: serial %b, expected %b", i, ifc4.txSerial, frameBit(8'hC3, i / 4));
      end
    end
    // Mid data bit 3, between clock edges.
    #1 reset = 1'b1;
    #1;
    assertCount++;
    if (ifc4.txSerial !== 1'b1 || ifc4.txStatus !== 32'h0) begin
      failCount++;
      $display("FAIL async_reset: serial %b status %h, expected 1 00000000", ifc4.txSerial, ifc4.txStatus);
    end
    @(negedge clock);
    assertCount++;
    if (ifc4.txSerial !== 1'b1 || ifc4.txStatus !== 32'h0) begin
      failCount++;
      $display("FAIL held_reset: serial %b status %h, expected 1 00000000", ifc4.txSerial, ifc4.txStatus);
    end
    reset = 1'b0;
    @(negedge clock);
    assertCount++;
    if (ifc4.txSerial !== 1'b0 || ifc4.txStatus !== 32'hC00000C3) begin
      failCount++;
      $display("FAIL restart: serial %b status %h, expected 0 C00000C3", ifc4.txSerial, ifc4.txStatus);
    end
    for (int i = 1; i < 40; i++) begin
      @(negedge clock);
      assertCount++;
      if (ifc4.txSerial !== frameBit(8'hC3, i / 4)) begin
        failCount++;
        $display("FAIL restart_line cycle %0d: serial %b, expected %b", i, ifc4.txSerial, frameBit(8'hC3, i / 4));
      end
    end
    @(negedge clock);
    assertCount++;
    if (ifc4.txStatus !== 32'h800100C3) begin
      failCount++;
      $display("FAIL restart_end: status %h, expected 800100C3", ifc4.txStatus);
    end
    $display("test_reset_mid_frame: abandoned frame, fresh 0xC3 frame, status %h", ifc4.txStatus);
  endtask

  task automatic test_wrap();
    logic       toggle;
    logic [7:0] data;
    logic [7:0] expCount;
    toggle = 1'b0;
    for (int f = 0; f < 256; f++) begin
      toggle   = ~toggle;
      data     = f[7:0];
      expCount = data + 8'd1;
      ifc2.txCommand = {toggle, 23'd0, data};
      for (int i = 0; i <= 20; i++) begin
        @(negedge clock);
        assertCount++;
        if (ifc2.txSerial !== ((i < 20) ? frameBit(data, i / 2) : 1'b1) ||
            ifc2.txStatus[30] !== (i < 20)) begin
          failCount++;
          $display("FAIL wrap_line frame %0d cycle %0d: serial %b busy %b, expected %b %b", f, i,
                   ifc2.txSerial, ifc2.txStatus[30], ((i < 20) ? frameBit(data, i / 2) : 1'b1), (i < 20));
        end
      end
      assertCount++;
      if (ifc2.txStatus[23:16] !== expCount || ifc2.txStatus[31] !== toggle) begin
        failCount++;
        $display("FAIL wrap_count frame %0d: count %h ack %b, expected %h %b",
                 f, ifc2.txStatus[23:16], ifc2.txStatus[31], expCount, toggle);
      end
      $display("test_wrap: frame %0d byte %h count %h", f, data, ifc2.txStatus[23:16]);
    end
    assertCount++;
    if (ifc2.txStatus !== 32'h000000FF) begin
      failCount++;
      $display("FAIL wrap_final: status %h, expected 000000FF", ifc2.txStatus);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_data_stability();
    test_reset_mid_frame();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
